// File: rtl/mc_ctrl.sv
// Multicycle MIPS-style control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// instruction decode, per-state control strobes and a retired-instruction counter.
module mc_ctrl #(
  parameter int ALUCTR_W = 5,
  parameter int CNT_W    = 16,
  parameter int MEM_WAIT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          op,
  input  logic [5:0]          func,
  input  logic                zero,
  input  logic                sign,
  input  logic                mem_ready,
  output logic [2:0]          state,
  output logic                PCWr,
  output logic                IRWr,
  output logic                MemRd,
  output logic                MemWr,
  output logic                RegWr,
  output logic                ALUSrc,
  output logic                MemtoReg,
  output logic                ExtOp,
  output logic [1:0]          PCSrc,
  output logic [1:0]          RegDst,
  output logic [ALUCTR_W-1:0] ALUctr,
  output logic                illegal,
  output logic                retire,
  output logic [CNT_W-1:0]    retire_cnt
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_J   = 2'd2;
  localparam logic [1:0] PC_RS  = 2'd3;

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;

  logic       is_rtype, is_jr, is_lw, is_sw, is_br, is_j, is_jal, is_ialu, is_ill;
  logic       ext_imm, br_taken, mem_ok;
  logic [3:0] alu_code;

  // With MEM_WAIT=0 every memory access is assumed to complete in one cycle.
  assign mem_ok = mem_ready | (MEM_WAIT == 0);

  always_comb begin
    is_rtype = 1'b0;
    is_jr    = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    is_br    = 1'b0;
    is_j     = 1'b0;
    is_jal   = 1'b0;
    is_ialu  = 1'b0;
    is_ill   = 1'b0;
    ext_imm  = 1'b0;
    alu_code = ALU_ADD;
    case (op)
      6'b000000: begin
        is_rtype = 1'b1;
        case (func)
          6'b100000, 6'b100001: alu_code = ALU_ADD;
          6'b100010, 6'b100011: alu_code = ALU_SUB;
          6'b100100:            alu_code = ALU_AND;
          6'b100101:            alu_code = ALU_OR;
          6'b100110:            alu_code = ALU_XOR;
          6'b100111:            alu_code = ALU_NOR;
          6'b101010:            alu_code = ALU_SLT;
          6'b101011:            alu_code = ALU_SLTU;
          6'b000000:            alu_code = ALU_SLL;
          6'b000010:            alu_code = ALU_SRL;
          6'b000011:            alu_code = ALU_SRA;
          6'b001000: begin
            is_rtype = 1'b0;
            is_jr    = 1'b1;
          end
          default: begin
            is_rtype = 1'b0;
            is_ill   = 1'b1;
          end
        endcase
      end
      6'b100011: begin
        is_lw   = 1'b1;
        ext_imm = 1'b1;
      end
      6'b101011: begin
        is_sw   = 1'b1;
        ext_imm = 1'b1;
      end
      6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
        is_br    = 1'b1;
        alu_code = ALU_SUB;
      end
      6'b000010: is_j   = 1'b1;
      6'b000011: is_jal = 1'b1;
      6'b001000, 6'b001001: begin
        is_ialu = 1'b1;
        ext_imm = 1'b1;
      end
      6'b001010: begin
        is_ialu  = 1'b1;
        ext_imm  = 1'b1;
        alu_code = ALU_SLT;
      end
      6'b001011: begin
        is_ialu  = 1'b1;
        ext_imm  = 1'b1;
        alu_code = ALU_SLTU;
      end
      6'b001100: begin
        is_ialu  = 1'b1;
        alu_code = ALU_AND;
      end
      6'b001101: begin
        is_ialu  = 1'b1;
        alu_code = ALU_OR;
      end
      6'b001110: begin
        is_ialu  = 1'b1;
        alu_code = ALU_XOR;
      end
      6'b001111: begin
        is_ialu  = 1'b1;
        alu_code = ALU_LUI;
      end
      default: is_ill = 1'b1;
    endcase
  end

  // Branch opcodes 000100..000111 select their condition by the low two op bits.
  always_comb begin
    case (op[1:0])
      2'b00:   br_taken = zero;
      2'b01:   br_taken = !zero;
      2'b10:   br_taken = sign | zero;
      default: br_taken = !sign && !zero;
    endcase
  end

  always_comb begin
    state_next = S_FETCH;
    PCWr       = 1'b0;
    IRWr       = 1'b0;
    MemRd      = 1'b0;
    MemWr      = 1'b0;
    RegWr      = 1'b0;
    ALUSrc     = 1'b0;
    MemtoReg   = 1'b0;
    ExtOp      = 1'b0;
    PCSrc      = PC_SEQ;
    RegDst     = 2'd0;
    illegal    = 1'b0;
    retire     = 1'b0;
    // Holding rst_n low silences every strobe even though the state is already FETCH.
    if (rst_n) begin
      case (state_reg)
        S_FETCH: begin
          MemRd = 1'b1;
          if (mem_ok) begin
            IRWr       = 1'b1;
            PCWr       = 1'b1;
            state_next = S_DECODE;
          end else begin
            state_next = S_FETCH;
          end
        end
        S_DECODE: begin
          if (is_ill) begin
            illegal = 1'b1;
          end else if (is_j || is_jal) begin
            PCWr   = 1'b1;
            PCSrc  = PC_J;
            retire = 1'b1;
            if (is_jal) begin
              RegWr  = 1'b1;
              RegDst = 2'd2;
            end
          end else if (is_jr) begin
            PCWr   = 1'b1;
            PCSrc  = PC_RS;
            retire = 1'b1;
          end else begin
            state_next = S_EXEC;
          end
        end
        S_EXEC: begin
          ExtOp = ext_imm;
          if (is_br) begin
            retire = 1'b1;
            if (br_taken) begin
              PCWr  = 1'b1;
              PCSrc = PC_BR;
            end
          end else if (is_lw || is_sw) begin
            ALUSrc     = 1'b1;
            state_next = S_MEM;
          end else begin
            ALUSrc     = is_ialu;
            state_next = S_WB;
          end
        end
        S_MEM: begin
          if (is_lw) begin
            MemRd      = 1'b1;
            state_next = mem_ok ? S_WB : S_MEM;
          end else begin
            MemWr      = 1'b1;
            retire     = mem_ok;
            state_next = mem_ok ? S_FETCH : S_MEM;
          end
        end
        S_WB: begin
          RegWr    = 1'b1;
          RegDst   = is_rtype ? 2'd1 : 2'd0;
          MemtoReg = is_lw;
          retire   = 1'b1;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign state      = state_reg;
  assign ALUctr     = ALUCTR_W'(alu_code);
  assign retire_cnt = cnt_reg;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed, table-driven bench for mc_ctrl: cycle-by-cycle vectors plus
// hand-written reset-during-MEM and counter-wrap sequences.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, func;
  logic       zero, sign, mem_ready;
  logic [2:0] state;
  logic       PCWr, IRWr, MemRd, MemWr, RegWr, ALUSrc, MemtoReg, ExtOp;
  logic [1:0] PCSrc, RegDst;
  logic [4:0] ALUctr;
  logic       illegal, retire;
  logic [3:0] retire_cnt;

  mc_ctrl #(.ALUCTR_W(5), .CNT_W(4), .MEM_WAIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero), .sign(sign),
    .mem_ready(mem_ready), .state(state), .PCWr(PCWr), .IRWr(IRWr), .MemRd(MemRd),
    .MemWr(MemWr), .RegWr(RegWr), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .ExtOp(ExtOp),
    .PCSrc(PCSrc), .RegDst(RegDst), .ALUctr(ALUctr), .illegal(illegal), .retire(retire),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // Observed vector: {state, strobes[9:0], PCSrc, RegDst, ALUctr}
  // strobe order: PCWr IRWr MemRd MemWr RegWr ALUSrc MemtoReg ExtOp illegal retire
  logic [21:0] act;
  assign act = {state, PCWr, IRWr, MemRd, MemWr, RegWr, ALUSrc, MemtoReg, ExtOp,
                illegal, retire, PCSrc, RegDst, ALUctr};

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  func;
    logic        zero;
    logic        sign;
    logic        mr;
    logic [21:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [3:0] cnt_model;

  task automatic r(input logic [5:0] o, input logic [5:0] f, input logic z, input logic s,
                   input logic mr, input logic [2:0] st, input logic [9:0] stb,
                   input logic [1:0] pcs, input logic [1:0] rd, input logic [4:0] alu);
    vec_t v;
    v.op = o; v.func = f; v.zero = z; v.sign = s; v.mr = mr;
    v.exp = {st, stb, pcs, rd, alu};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, a, e);
    end
  endtask

  // Common prefix: FETCH (mem_ready=1) then DECODE for an instruction that continues to EXEC.
  task automatic fd(input logic [5:0] o, input logic [5:0] f, input logic [4:0] alu);
    r(o, f, 0, 0, 1, 3'd0, 10'b1110000000, 2'd0, 2'd0, alu);
    r(o, f, 0, 0, 1, 3'd1, 10'b0000000000, 2'd0, 2'd0, alu);
  endtask

  task automatic rtype(input logic [5:0] f, input logic [4:0] alu);
    fd(6'h00, f, alu);
    r(6'h00, f, 0, 0, 1, 3'd2, 10'b0000000000, 2'd0, 2'd0, alu);
    r(6'h00, f, 0, 0, 1, 3'd4, 10'b0000100001, 2'd0, 2'd1, alu);
  endtask

  task automatic ialu(input logic [5:0] o, input logic ext, input logic [4:0] alu);
    fd(o, 6'h00, alu);
    r(o, 6'h00, 0, 0, 1, 3'd2, {7'b0000010, ext, 2'b00}, 2'd0, 2'd0, alu);
    r(o, 6'h00, 0, 0, 1, 3'd4, 10'b0000100001, 2'd0, 2'd0, alu);
  endtask

  task automatic branch(input logic [5:0] o, input logic z, input logic s, input logic taken);
    r(o, 6'h00, z, s, 1, 3'd0, 10'b1110000000, 2'd0, 2'd0, 5'd1);
    r(o, 6'h00, z, s, 1, 3'd1, 10'b0000000000, 2'd0, 2'd0, 5'd1);
    r(o, 6'h00, z, s, 1, 3'd2, {taken, 8'b00000000, 1'b1}, taken ? 2'd1 : 2'd0, 2'd0, 5'd1);
  endtask

  task automatic jump(input logic [5:0] o, input logic [5:0] f, input logic [9:0] stb,
                      input logic [1:0] pcs, input logic [1:0] rd);
    r(o, f, 0, 0, 1, 3'd0, 10'b1110000000, 2'd0, 2'd0, 5'd0);
    r(o, f, 0, 0, 1, 3'd1, stb, pcs, rd, 5'd0);
  endtask

  initial begin
    rst_n = 1'b0; op = 6'h00; func = 6'h20; zero = 1'b0; sign = 1'b0; mem_ready = 1'b1;

    // FETCH stall, then add (4 cycles)
    r(6'h00, 6'h20, 0, 0, 0, 3'd0, 10'b0010000000, 2'd0, 2'd0, 5'd0);
    rtype(6'h20, 5'd0);
    rtype(6'h22, 5'd1);
    rtype(6'h03, 5'd10);
    // lw with three mem_ready-low MEM cycles: 8 cycles total
    fd(6'h23, 6'h00, 5'd0);
    r(6'h23, 6'h00, 0, 0, 1, 3'd2, 10'b0000010100, 2'd0, 2'd0, 5'd0);
    for (int i = 0; i < 3; i++)
      r(6'h23, 6'h00, 0, 0, 0, 3'd3, 10'b0010000000, 2'd0, 2'd0, 5'd0);
    r(6'h23, 6'h00, 0, 0, 1, 3'd3, 10'b0010000000, 2'd0, 2'd0, 5'd0);
    r(6'h23, 6'h00, 0, 0, 1, 3'd4, 10'b0000101001, 2'd0, 2'd0, 5'd0);
    // sw with one stall cycle in MEM
    fd(6'h2B, 6'h00, 5'd0);
    r(6'h2B, 6'h00, 0, 0, 1, 3'd2, 10'b0000010100, 2'd0, 2'd0, 5'd0);
    r(6'h2B, 6'h00, 0, 0, 0, 3'd3, 10'b0001000000, 2'd0, 2'd0, 5'd0);
    r(6'h2B, 6'h00, 0, 0, 1, 3'd3, 10'b0001000001, 2'd0, 2'd0, 5'd0);
    // branches
    branch(6'h04, 0, 0, 0);
    branch(6'h05, 0, 0, 1);
    branch(6'h06, 0, 1, 1);
    branch(6'h07, 1, 0, 0);
    // jumps
    jump(6'h03, 6'h00, 10'b1000100001, 2'd2, 2'd2);
    jump(6'h02, 6'h00, 10'b1000000001, 2'd2, 2'd0);
    jump(6'h00, 6'h08, 10'b1000000001, 2'd3, 2'd0);
    // illegal op and illegal R-type func
    jump(6'h3F, 6'h00, 10'b0000000010, 2'd0, 2'd0);
    jump(6'h00, 6'h01, 10'b0000000010, 2'd0, 2'd0);
    // I-type ALU
    ialu(6'h0D, 1'b0, 5'd3);
    ialu(6'h0F, 1'b0, 5'd11);
    ialu(6'h0A, 1'b1, 5'd6);

    // Reset state
    #2;
    check("reset_outputs", 32'(act), 32'(22'h0));
    check("reset_cnt", 32'(retire_cnt), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    cnt_model = 4'd0;
    for (int i = 0; i < vecs.size(); i++) begin
      op = vecs[i].op; func = vecs[i].func; zero = vecs[i].zero;
      sign = vecs[i].sign; mem_ready = vecs[i].mr;
      #1;
      check($sformatf("vec%0d_out", i), 32'(act), 32'(vecs[i].exp));
      check($sformatf("vec%0d_cnt", i), 32'(retire_cnt), 32'(cnt_model));
      $display("[TB] vec %0d op=%02h func=%02h state=%0d out=%06h cnt=%0d",
               i, op, func, state, act, retire_cnt);
      if (vecs[i].exp[9]) cnt_model = cnt_model + 4'd1;
      @(negedge clk);
    end

    // sw stalled in MEM, then reset dropped mid-cycle
    op = 6'h2B; func = 6'h00; zero = 1'b0; sign = 1'b0; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check("sw_mem_state", 32'(state), 32'd3);
    check("sw_mem_memwr", 32'(MemWr), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_state", 32'(state), 32'd0);
    check("rst_mid_memwr", 32'(MemWr), 32'd0);
    check("rst_mid_strobes", 32'(act[18:9]), 32'd0);
    check("rst_mid_cnt", 32'(retire_cnt), 32'd0);
    $display("[TB] reset in MEM: state=%0d MemWr=%0d cnt=%0d", state, MemWr, retire_cnt);

    // Release, then 17 back-to-back j instructions wrap the 4-bit counter to 1
    @(negedge clk);
    rst_n = 1'b1; op = 6'h02; mem_ready = 1'b1;
    #1;
    check("post_rst_fetch", 32'(state), 32'd0);
    check("post_rst_memrd", 32'(MemRd), 32'd1);
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      if (i == 0) begin
        #1;
        check("post_rst_decode", 32'(state), 32'd1);
      end
    end
    #1;
    check("j17_cnt", 32'(retire_cnt), 32'd1);
    check("j17_state", 32'(state), 32'd0);
    $display("[TB] 17 j retired: cnt=%0d state=%0d", retire_cnt, state);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
